render_frame: RTL and testbench
===============================

RENDER_FRAME -- requirements
Module: render_frame

Interface
REQ-001 Parameter SCREEN_W, default 160, number of screen columns.
REQ-002 Parameter SCREEN_H, default 120, number of screen rows.
REQ-003 Parameter CEIL_COLOUR, default 3'b001, ceiling colour.
REQ-004 Parameter FLOOR_COLOUR, default 3'b010, floor colour.
REQ-005 Parameter WALL_COLOUR, default 3'b111, wall colour.
REQ-006 clock  input  1  system clock; all logic on its rising edge.
REQ-007 resetn  input  1  reset, synchronous, active-low.
REQ-008 start_frame  input  1  request to render one full frame.
REQ-009 slice_size  input  7  projected wall height from the slice-size stage.
REQ-010 end_calc  input  1  slice-size stage result valid, single-cycle pulse.
REQ-011 begin_calc  output  1  single-cycle request to the slice-size stage.
REQ-012 column_count  output  8  column currently being cast; held stable from begin_calc until end_calc.
REQ-013 x  output  8  pixel x to the VGA adapter.
REQ-014 y  output  7  pixel y to the VGA adapter.
REQ-015 colour  output  3  pixel colour.
REQ-016 plot  output  1  pixel write enable.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 frame_done  output  1  single-cycle pulse after the last pixel of the frame.

Function
REQ-019 The FSM states SHALL be IDLE, REQ, WAIT_CALC, BOUNDS, DRAW, NEXT_COL, and DONE.
REQ-020 From IDLE, start_frame SHALL clear column_count to 0 and move to REQ; start_frame outside IDLE SHALL be ignored.
REQ-021 REQ SHALL assert begin_calc for exactly one cycle and then move to WAIT_CALC.
REQ-022 WAIT_CALC SHALL wait with no timeout; on end_calc it SHALL latch slice_size and move to BOUNDS; end_calc in any other state SHALL be ignored.
REQ-023 BOUNDS computation:
- h = min(slice_size, SCREEN_H).
- top = (SCREEN_H - h) >> 1, with odd remainders floored.
- bot = top + h.
- Clear the row counter, then move to DRAW.
REQ-024 DRAW SHALL emit exactly one pixel per cycle:
- plot = 1, x = column_count, y = row counter.
- Rows 0..SCREEN_H-1 in order.
REQ-025 Pixel colour in DRAW:
- Row < top: CEIL_COLOUR.
- top <= row < bot: wall colour.
- Row >= bot: FLOOR_COLOUR.
REQ-026 h = 0 SHALL produce no wall pixels; h = SCREEN_H SHALL produce all wall pixels.
REQ-027 After row SCREEN_H-1, DRAW SHALL move to NEXT_COL.
REQ-028 NEXT_COL SHALL go to DONE if column_count = SCREEN_W-1; otherwise it SHALL increment column_count and go to REQ.
REQ-029 DONE SHALL pulse frame_done for one cycle and return to IDLE; column_count SHALL hold SCREEN_W-1.
REQ-030 Per-column cycle cost SHALL be 3 + L + SCREEN_H, where L is the cycles from begin_calc to end_calc (L >= 1).
REQ-031 plot SHALL be 0 outside DRAW; x, y, and colour are don't-care when plot = 0.

Reset
REQ-032 On resetn = 0 at a clock edge, the block SHALL:
- Enter IDLE.
- Drive begin_calc, plot, busy, frame_done, x, y, colour, and column_count to 0.
- Clear the latched slice and the row counter.
REQ-033 Reset mid-frame SHALL abort immediately with no frame_done and no further plot; any pending end_calc is discarded.

Configuration
REQ-034 Macro RENDER_SHADE_EN SHALL control wall shading:
- Defined: wall colour = WALL_COLOUR when h >= SCREEN_H/3 (>= 40), otherwise 3'b011 (far walls dimmer).
- Undefined: wall colour = WALL_COLOUR for all h.
- Timing and FSM are identical in both builds.

Structure
REQ-035 Shared package render_pkg SHALL hold:
- SCREEN_W and SCREEN_H defaults.
- The colour constants (including the shade colour 3'b011).
- The FSM state enumeration.
REQ-036 One combinational sub-module, column_bounds, SHALL compute h, top, and bot from slice_size.

Verification
REQ-037 start_frame with end_calc returned 2 cycles after every begin_calc -> 160 begin_calc pulses, 19200 plot cycles, one frame_done; frame total 160*(3+2+120) = 20000 cycles from REQ entry.
REQ-038 slice_size = 40 -> rows 0..39 CEIL_COLOUR, rows 40..79 wall, rows 80..119 FLOOR_COLOUR.
REQ-039 Boundary sizes:
- slice_size = 0 -> rows 0..59 CEIL_COLOUR, rows 60..119 FLOOR_COLOUR.
- slice_size = 127 -> all 120 rows wall.
- slice_size = 41 -> top = 39, bot = 80.
REQ-040 Shading by build:
- RENDER_SHADE_EN defined: slice_size 39 -> wall 3'b011; slice_size 40 -> 3'b111.
- RENDER_SHADE_EN undefined: both give 3'b111.
REQ-041 Stray inputs:
- start_frame mid-frame -> no effect.
- end_calc during DRAW -> ignored, no column skip.
REQ-042 resetn low during column 57 DRAW -> next cycle plot = 0, busy = 0, column_count = 0, no frame_done; new start_frame renders from column 0.

Source files
------------

// File: rtl/render_pkg.sv
// render_pkg -- shared definitions for the frame renderer.
//   Screen geometry defaults, the colour palette (including the dimmed
//   far-wall shade) and the renderer FSM state enumeration.
package render_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam logic [2:0] CEIL_COLOUR_DEF  = 3'b001;
    localparam logic [2:0] FLOOR_COLOUR_DEF = 3'b010;
    localparam logic [2:0] WALL_COLOUR_DEF  = 3'b111;
    // Colour for distant (short) walls when shading is built in.
    localparam logic [2:0] SHADE_COLOUR     = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_CALC,
        BOUNDS,
        DRAW,
        NEXT_COL,
        DONE
    } state_t;

endpackage

// File: rtl/column_bounds.sv
// column_bounds -- combinational vertical extent of one wall slice.
//   slice_size : projected wall height from the slice-size stage
//   h          : slice height clipped to the screen height
//   top        : first wall row, (SCREEN_H - h) / 2 rounded down
//   bot        : first floor row below the wall (top + h)
import render_pkg::*;

module column_bounds #(
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic [6:0] slice_size,
    output logic [6:0] h,
    output logic [6:0] top,
    output logic [6:0] bot
);

    localparam logic [6:0] SCREEN_H7 = 7'(SCREEN_H);

    always_comb begin
        h   = (slice_size > SCREEN_H7) ? SCREEN_H7 : slice_size;
        top = (SCREEN_H7 - h) >> 1;
        bot = top + h;
    end

endmodule

// File: rtl/render_frame.sv
// render_frame -- renders one frame column by column for a VGA adapter.
//   For each column it asks the slice-size stage for a wall height, then
//   writes every row of that column: ceiling above the wall, wall, floor.
//
// Ports:
//   clock, resetn      : clock (rising edge), synchronous active-low reset
//   start_frame        : start one frame (only honoured while idle)
//   slice_size,end_calc: slice-size stage result and its valid pulse
//   begin_calc         : one-cycle request to the slice-size stage
//   column_count       : column being cast, stable from begin_calc to end_calc
//   x, y, colour, plot : pixel write to the VGA adapter
//   busy               : high whenever the FSM is not idle
//   frame_done         : one-cycle pulse once the last pixel is written
//   state              : current FSM state, for observation only
//
// Build option: define RENDER_SHADE_EN to draw short (distant) walls in
// the dimmer SHADE_COLOUR; timing is the same with or without it.
//
// Slice-size handshake: begin_calc is a single-cycle request issued while
// column_count already holds the column; the stage answers any number of
// cycles later (at least one) with a single-cycle end_calc carrying
// slice_size. Only one request is ever outstanding, and end_calc is only
// accepted in WAIT_CALC -- a pulse at any other time is dropped.
import render_pkg::*;

module render_frame #(
    parameter int         SCREEN_W     = SCREEN_W_DEF,
    parameter int         SCREEN_H     = SCREEN_H_DEF,
    parameter logic [2:0] CEIL_COLOUR  = CEIL_COLOUR_DEF,
    parameter logic [2:0] FLOOR_COLOUR = FLOOR_COLOUR_DEF,
    parameter logic [2:0] WALL_COLOUR  = WALL_COLOUR_DEF
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start_frame,
    input  logic [6:0] slice_size,
    input  logic       end_calc,
    output logic       begin_calc,
    output logic [7:0] column_count,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done,
    output state_t     state
);

    localparam logic [7:0] LAST_COL = 8'(SCREEN_W - 1);
    localparam logic [6:0] LAST_ROW = 7'(SCREEN_H - 1);
`ifdef RENDER_SHADE_EN
    localparam logic [6:0] SHADE_MIN = 7'(SCREEN_H / 3);
`endif

    logic [6:0] slice_q;
    logic [6:0] row;
    logic [6:0] h, top, bot;
    logic [6:0] next_row;
    logic [2:0] wall_colour;
    logic [2:0] next_colour;

    column_bounds #(.SCREEN_H(SCREEN_H)) u_bounds (
        .slice_size (slice_q),
        .h          (h),
        .top        (top),
        .bot        (bot)
    );

    always_comb begin
`ifdef RENDER_SHADE_EN
        wall_colour = (h >= SHADE_MIN) ? WALL_COLOUR : SHADE_COLOUR;
`else
        wall_colour = WALL_COLOUR;
`endif
    end

    // Pixel outputs are registered, so the row/colour computed here is the
    // one presented during the following cycle. BOUNDS primes row 0.
    always_comb begin
        next_row = (state == DRAW) ? row + 7'd1 : 7'd0;
        if (next_row < top) begin
            next_colour = CEIL_COLOUR;
        end else if ((h != 7'd0) && (next_row < bot)) begin
            // An empty slice has top == bot and so no wall band at all.
            next_colour = wall_colour;
        end else begin
            next_colour = FLOOR_COLOUR;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= IDLE;
            begin_calc   <= 1'b0;
            column_count <= 8'd0;
            x            <= 8'd0;
            y            <= 7'd0;
            colour       <= 3'd0;
            plot         <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            slice_q      <= 7'd0;
            row          <= 7'd0;
        end else begin
            begin_calc <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_frame) begin
                        column_count <= 8'd0;
                        busy         <= 1'b1;
                        begin_calc   <= 1'b1;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    state <= WAIT_CALC;
                end
                WAIT_CALC: begin
                    if (end_calc) begin
                        slice_q <= slice_size;
                        state   <= BOUNDS;
                    end
                end
                BOUNDS: begin
                    row    <= next_row;
                    plot   <= 1'b1;
                    x      <= column_count;
                    y      <= next_row;
                    colour <= next_colour;
                    state  <= DRAW;
                end
                DRAW: begin
                    if (row == LAST_ROW) begin
                        plot  <= 1'b0;
                        state <= NEXT_COL;
                    end else begin
                        row    <= next_row;
                        y      <= next_row;
                        colour <= next_colour;
                    end
                end
                NEXT_COL: begin
                    if (column_count == LAST_COL) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        column_count <= column_count + 8'd1;
                        begin_calc   <= 1'b1;
                        state        <= REQ;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_render_frame.sv
// tb_render_frame -- self-checking bench for render_frame (default geometry).
//   Plays the slice-size stage, keeps a per-pixel expected queue built from
//   the column extent rules, and checks every plotted pixel against it.
module tb_render_frame;
    import render_pkg::*;

    localparam logic [2:0] C_CEIL  = 3'b001;
    localparam logic [2:0] C_FLOOR = 3'b010;
    localparam logic [2:0] C_WALL  = 3'b111;
`ifdef RENDER_SHADE_EN
    localparam logic [2:0] C_FAR   = 3'b011;
`else
    localparam logic [2:0] C_FAR   = 3'b111;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic       clock = 1'b0;
    logic       resetn;
    logic       start_frame;
    logic [6:0] slice_size;
    logic       end_calc;
    logic       begin_calc;
    logic [7:0] column_count;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       frame_done;
    state_t     state;

    always #5 clock = ~clock;

    render_frame dut (
        .clock        (clock),
        .resetn       (resetn),
        .start_frame  (start_frame),
        .slice_size   (slice_size),
        .end_calc     (end_calc),
        .begin_calc   (begin_calc),
        .column_count (column_count),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .busy         (busy),
        .frame_done   (frame_done),
        .state        (state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int nbegin = 0;
    int nplot  = 0;
    int ndone  = 0;
    bit lat_mode = 1'b0;   // 0: answer after 2 cycles, 1: after 1..3 cycles
    bit stray_en = 1'b0;   // inject an end_calc pulse in the middle of DRAW
    logic [17:0] exp_q[$]; // {x, y, colour} per expected pixel

    int slice_tab[12] = '{40, 0, 127, 41, 39, 120, 60, 1, 119, 121, 80, 2};

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int col);
        return lat_mode ? 1 + (col % 3) : 2;
    endfunction

    // Expected colour of row r for a slice of size s, straight from the
    // screen geometry: centred wall band of height min(s,120).
    function automatic logic [2:0] model_colour(input int s, input int r);
        int h, top, bot;
        h   = (s < 120) ? s : 120;
        top = (120 - h) / 2;
        bot = top + h;
        if (r < top) return C_CEIL;
        if (r < bot) return (h >= 40) ? C_WALL : C_FAR;
        return C_FLOOR;
    endfunction

    // Hand-computed pixels that pin the model: columns 0..4 receive
    // slices 40, 0, 127, 41, 39. Returns -1 where nothing is pinned.
    function automatic int lit_colour(input int xx, input int yy);
        if (xx == 0 && yy == 39)  return 1;
        if (xx == 0 && yy == 40)  return 7;
        if (xx == 0 && yy == 79)  return 7;
        if (xx == 0 && yy == 80)  return 2;
        if (xx == 1 && yy == 59)  return 1;
        if (xx == 1 && yy == 60)  return 2;
        if (xx == 2 && yy == 0)   return 7;
        if (xx == 2 && yy == 119) return 7;
        if (xx == 3 && yy == 38)  return 1;
        if (xx == 3 && yy == 39)  return 7;
        if (xx == 3 && yy == 79)  return 7;
        if (xx == 3 && yy == 80)  return 2;
        if (xx == 4 && yy == 39)  return 1;
        if (xx == 4 && yy == 40)  return int'(C_FAR);
        if (xx == 4 && yy == 78)  return int'(C_FAR);
        if (xx == 4 && yy == 79)  return 2;
        return -1;
    endfunction

    // ---------------- slice-stage responder + scoreboard ----------------
    initial begin : monitor
        int wait_cnt;
        int stray_cnt;
        int model_col;
        int s;
        int lc;
        logic [17:0] got;
        logic [17:0] exp;
        wait_cnt  = 0;
        stray_cnt = 0;
        model_col = 0;
        end_calc  = 1'b0;
        slice_size = 7'd0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                exp_q.delete();
                model_col = 0;
                wait_cnt  = 0;
                stray_cnt = 0;
                end_calc  = 1'b0;
                continue;
            end
            end_calc = 1'b0;
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    s = slice_tab[model_col % 12];
                    check("col_held", column_count, model_col);
                    slice_size = 7'(s);
                    end_calc   = 1'b1;
                    for (int r = 0; r < 120; r++)
                        exp_q.push_back({8'(model_col), 7'(r), model_colour(s, r)});
                    model_col++;
                    if (stray_en) stray_cnt = 10;
                end
            end else if (stray_cnt > 0) begin
                stray_cnt--;
                if (stray_cnt == 0) begin
                    slice_size = (slice_size == 7'd0) ? 7'd127 : 7'd0;
                    end_calc   = 1'b1;
                end
            end
            if (begin_calc) begin
                nbegin++;
                check("col_at_begin", column_count, model_col);
                check("busy_at_begin", busy, 1);
                wait_cnt = lat_of(model_col);
            end
            if (plot) begin
                nplot++;
                got = {x, y, colour};
                check("plot_has_model_pixel", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    check("pixel_xyc", got, exp);
                end
                lc = lit_colour(int'(x), int'(y));
                if (lc >= 0) check("pinned_colour", colour, lc);
            end
            if (frame_done) begin
                ndone++;
                model_col = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_frame(input int exp_len, input bit stray_start);
        int n;
        int b0, p0, d0;
        bit done;
        b0 = nbegin;
        p0 = nplot;
        d0 = ndone;
        @(negedge clock);
        start_frame = 1'b1;
        @(negedge clock);
        start_frame = 1'b0;   // this cycle is REQ of column 0
        n = 0;
        done = 1'b0;
        while (!done && n < exp_len + 1000) begin
            @(negedge clock);
            n++;
            if (stray_start) start_frame = (n == 500);
            if (frame_done) done = 1'b1;
        end
        start_frame = 1'b0;
        check("frame_len", n, exp_len);
        @(negedge clock);
        check("begin_count", nbegin - b0, 160);
        check("plot_count", nplot - p0, 19200);
        check("done_count", ndone - d0, 1);
        check("busy_after_frame", busy, 0);
        check("model_queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- main sequence + report ----------------
    initial begin : main
        int exp_len;
        int n;
        int d0;
        resetn = 1'b0;
        start_frame = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_state", state, IDLE);
        check("rst_begin_calc", begin_calc, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_column_count", column_count, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_busy", busy, 0);

        // Frame A: constant 2-cycle latency, 160*(3+2+120) cycles.
        lat_mode = 1'b0;
        stray_en = 1'b0;
        run_frame(20000, 1'b0);

        // Frame B: latency 1..3, stray end_calc in DRAW, stray start_frame.
        lat_mode = 1'b1;
        stray_en = 1'b1;
        exp_len = 0;
        for (int c = 0; c < 160; c++) exp_len += 123 + lat_of(c);
        run_frame(exp_len, 1'b1);
        repeat (5) @(negedge clock);
        check("stray_start_ignored", busy, 0);

        // Frame C: reset in the middle of column 57.
        lat_mode = 1'b0;
        stray_en = 1'b0;
        d0 = ndone;
        @(negedge clock);
        start_frame = 1'b1;
        @(negedge clock);
        start_frame = 1'b0;
        n = 0;
        while (!(plot && x == 8'd57 && y == 7'd10) && n < 10000) begin
            @(negedge clock);
            n++;
        end
        check("reached_col57", plot && x == 8'd57, 1);
        resetn = 1'b0;
        @(negedge clock);
        check("abort_plot", plot, 0);
        check("abort_busy", busy, 0);
        check("abort_column_count", column_count, 0);
        check("abort_frame_done", frame_done, 0);
        check("abort_begin_calc", begin_calc, 0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (10) @(negedge clock);
        check("abort_no_done", ndone - d0, 0);
        check("abort_idle", busy, 0);

        // Frame D: a fresh frame after the abort starts at column 0.
        run_frame(20000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
